// File: rtl/sh_mdu_pkg.sv
// rtl/sh_mdu_pkg.sv - shared opcodes, states and saturation bounds for the SH-4 MDU
package sh_mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MDU_MULL   = 3'd0;
    localparam logic [2:0] MDU_MULSW  = 3'd1;
    localparam logic [2:0] MDU_MULUW  = 3'd2;
    localparam logic [2:0] MDU_DMULS  = 3'd3;
    localparam logic [2:0] MDU_DMULU  = 3'd4;
    localparam logic [2:0] MDU_MACW   = 3'd5;
    localparam logic [2:0] MDU_MACL   = 3'd6;
    localparam logic [2:0] MDU_CLRMAC = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_t;

    localparam logic [63:0] SAT48_MAX = 64'h00007FFF_FFFFFFFF;
    localparam logic [63:0] SAT48_MIN = 64'hFFFF8000_00000000;
    localparam logic [31:0] SAT32_MAX = 32'h7FFFFFFF;
    localparam logic [31:0] SAT32_MIN = 32'h80000000;

endpackage

// File: rtl/sh_mdu_if.sv
// rtl/sh_mdu_if.sv - request/completion handshake, LDS write port and MAC outputs
interface sh_mdu_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic        in_s;
    logic [31:0] in_opl;
    logic [31:0] in_oph;
    logic        out_valid;
    logic        out_ready;
    logic        wr_en;
    logic        wr_sel;
    logic [31:0] wr_data;
    logic [31:0] mach;
    logic [31:0] macl;

    modport master (
        output in_valid, in_op, in_s, in_opl, in_oph, out_ready, wr_en, wr_sel, wr_data,
        input  in_ready, out_valid, mach, macl
    );

    modport slave (
        input  in_valid, in_op, in_s, in_opl, in_oph, out_ready, wr_en, wr_sel, wr_data,
        output in_ready, out_valid, mach, macl
    );
endinterface

// File: rtl/sh_mdu_step.sv
// rtl/sh_mdu_step.sv - one combinational shift-add step of the iterative multiplier
import sh_mdu_pkg::*;

module sh_mdu_step #(
    parameter int STEP_BITS = 8
) (
    input  logic [XLEN-1:0]      i_mcand,
    input  logic [STEP_BITS-1:0] i_chunk,
    input  logic [5:0]           i_shift,
    input  logic [2*XLEN-1:0]    i_partial,
    output logic [2*XLEN-1:0]    o_partial
);
    logic [2*XLEN-1:0] w_pp;

    assign w_pp      = {{XLEN{1'b0}}, i_mcand} * {{(2*XLEN-STEP_BITS){1'b0}}, i_chunk};
    assign o_partial = i_partial + (w_pp << i_shift);
endmodule

// File: rtl/sh_mdu_iter.sv
// rtl/sh_mdu_iter.sv - iterative MUL/DMUL/MAC unit holding MACH:MACL
// Optional SH_MDU_EARLY_OUT_EN: leave MUL once the remaining multiplier bits are zero.
import sh_mdu_pkg::*;

module sh_mdu_iter #(
    parameter int STEP_BITS = 8
) (
    input  logic     clk,
    input  logic     rst,
    sh_mdu_if.slave  bus
);
    localparam logic [5:0] CNT16     = 6'((16 / STEP_BITS < 1) ? 1 : 16 / STEP_BITS);
    localparam logic [5:0] CNT32     = 6'((32 / STEP_BITS < 1) ? 1 : 32 / STEP_BITS);
    localparam logic [5:0] SHIFT_INC = 6'(STEP_BITS);

    mdu_state_t  r_state;
    logic [2:0]  r_op;
    logic        r_s;
    logic        r_sign;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_partial;
    logic [5:0]  r_shift;
    logic [5:0]  r_cnt;
    logic [31:0] r_mach;
    logic [31:0] r_macl;
    logic        r_in_ready;
    logic        r_out_valid;

    logic        w_wide;
    logic        w_signed;
    logic [31:0] w_a_ext;
    logic [31:0] w_b_ext;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_partial_nxt;
    logic [31:0] w_mplier_nxt;
    logic        w_last;
    logic [63:0] w_prod;
    logic [64:0] w_sum65;
    logic [32:0] w_sum33;

    assign w_wide   = (bus.in_op == MDU_MULL) || (bus.in_op == MDU_DMULS) ||
                      (bus.in_op == MDU_DMULU) || (bus.in_op == MDU_MACL);
    assign w_signed = (bus.in_op == MDU_MULSW) || (bus.in_op == MDU_DMULS) ||
                      (bus.in_op == MDU_MACW) || (bus.in_op == MDU_MACL);

    assign w_a_ext = w_wide ? bus.in_opl :
                     (w_signed ? {{16{bus.in_opl[15]}}, bus.in_opl[15:0]} : {16'b0, bus.in_opl[15:0]});
    assign w_b_ext = w_wide ? bus.in_oph :
                     (w_signed ? {{16{bus.in_oph[15]}}, bus.in_oph[15:0]} : {16'b0, bus.in_oph[15:0]});

    // Magnitudes are unsigned, so -2^31 maps onto 0x80000000 without overflow.
    assign w_a_mag = (w_signed && w_a_ext[31]) ? (~w_a_ext + 32'd1) : w_a_ext;
    assign w_b_mag = (w_signed && w_b_ext[31]) ? (~w_b_ext + 32'd1) : w_b_ext;

    sh_mdu_step #(.STEP_BITS(STEP_BITS)) u_step (
        .i_mcand   (r_mcand),
        .i_chunk   (r_mplier[STEP_BITS-1:0]),
        .i_shift   (r_shift),
        .i_partial (r_partial),
        .o_partial (w_partial_nxt)
    );

    assign w_mplier_nxt = r_mplier >> STEP_BITS;
`ifdef SH_MDU_EARLY_OUT_EN
    assign w_last = (r_cnt == 6'd1) || (w_mplier_nxt == 32'd0);
`else
    assign w_last = (r_cnt == 6'd1);
`endif
    assign w_prod = r_sign ? (~w_partial_nxt + 64'd1) : w_partial_nxt;

    // One extra bit of headroom lets saturation see true overflow, not the wrapped sum.
    assign w_sum65 = {r_mach[31], r_mach, r_macl} + {r_partial[63], r_partial};
    assign w_sum33 = {r_macl[31], r_macl} + {r_partial[31], r_partial[31:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= MDU_MULL;
            r_s         <= 1'b0;
            r_sign      <= 1'b0;
            r_mcand     <= 32'd0;
            r_mplier    <= 32'd0;
            r_partial   <= 64'd0;
            r_shift     <= 6'd0;
            r_cnt       <= 6'd0;
            r_mach      <= 32'd0;
            r_macl      <= 32'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.wr_en) begin
                        if (bus.wr_sel) r_mach <= bus.wr_data;
                        else            r_macl <= bus.wr_data;
                    end
                    if (bus.in_valid) begin
                        r_op       <= bus.in_op;
                        r_s        <= bus.in_s;
                        r_sign     <= w_signed && (w_a_ext[31] ^ w_b_ext[31]);
                        r_mcand    <= w_a_mag;
                        r_mplier   <= w_b_mag;
                        r_partial  <= 64'd0;
                        r_shift    <= 6'd0;
                        r_cnt      <= w_wide ? CNT32 : CNT16;
                        r_in_ready <= 1'b0;
                        if (bus.in_op == MDU_CLRMAC) begin
                            r_mach      <= 32'd0;
                            r_macl      <= 32'd0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    r_partial <= w_last ? w_prod : w_partial_nxt;
                    r_mplier  <= w_mplier_nxt;
                    r_shift   <= r_shift + SHIFT_INC;
                    r_cnt     <= r_cnt - 6'd1;
                    if (w_last) r_state <= S_ACC;
                end
                S_ACC: begin
                    case (r_op)
                        MDU_MULL, MDU_MULSW, MDU_MULUW: r_macl <= r_partial[31:0];
                        MDU_DMULS, MDU_DMULU: {r_mach, r_macl} <= r_partial;
                        MDU_MACL: begin
                            if (r_s && !(&w_sum65[64:47]) && (|w_sum65[64:47]))
                                {r_mach, r_macl} <= w_sum65[64] ? SAT48_MIN : SAT48_MAX;
                            else
                                {r_mach, r_macl} <= w_sum65[63:0];
                        end
                        MDU_MACW: begin
                            if (!r_s)
                                {r_mach, r_macl} <= w_sum65[63:0];
                            else if (w_sum33[32] != w_sum33[31])
                                r_macl <= w_sum33[32] ? SAT32_MIN : SAT32_MAX;
                            else
                                r_macl <= w_sum33[31:0];
                        end
                        default: ;
                    endcase
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.mach      = r_mach;
    assign bus.macl      = r_macl;
endmodule

// File: tb/tb_sh_mdu_iter.sv
// tb/tb_sh_mdu_iter.sv - directed vector bench for sh_mdu_iter at STEP_BITS=8
import sh_mdu_pkg::*;

module tb_sh_mdu_iter;
    logic clk;
    logic rst;
    sh_mdu_if bus ();

    sh_mdu_iter #(.STEP_BITS(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        s;
        logic [31:0] mach0;
        logic [31:0] macl0;
        logic [31:0] opl;
        logic [31:0] oph;
        logic [31:0] exp_mach;
        logic [31:0] exp_macl;
        int          lat;
    } vec_t;

    vec_t vecs [14];
    int   n_cmp = 0;
    int   n_err = 0;
    int   lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic lds(input logic sel, input logic [31:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 1;
        while (!bus.out_valid && l < 200) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic s, input logic [31:0] a,
                          input logic [31:0] b, output int l);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_s = s; bus.in_opl = a; bus.in_oph = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(l);
    endtask

    initial begin
        vecs[0]  = '{MDU_MULSW,  1'b0, 32'hAAAA5555, 32'h0,        32'h0000FFFE, 32'h3,        32'hAAAA5555, 32'hFFFFFFFA, 4};
        vecs[1]  = '{MDU_MULUW,  1'b0, 32'h11111111, 32'h0,        32'h1234FFFE, 32'h3,        32'h11111111, 32'h0002FFFA, 4};
        vecs[2]  = '{MDU_MULL,   1'b0, 32'h22222222, 32'h0,        32'hFFFFFFFF, 32'h2,        32'h22222222, 32'hFFFFFFFE, 6};
        vecs[3]  = '{MDU_DMULU,  1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 6};
        vecs[4]  = '{MDU_DMULS,  1'b0, 32'h5,        32'h5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 6};
        vecs[5]  = '{MDU_DMULS,  1'b0, 32'h0,        32'h0,        32'h80000000, 32'h2,        32'hFFFFFFFF, 32'h00000000, 6};
        vecs[6]  = '{MDU_MACL,   1'b1, 32'h00007FFF, 32'hFFFFFFF0, 32'h10,       32'h10,       32'h00007FFF, 32'hFFFFFFFF, 6};
        vecs[7]  = '{MDU_MACL,   1'b0, 32'h00007FFF, 32'hFFFFFFF0, 32'h10,       32'h10,       32'h00008000, 32'h000000F0, 6};
        vecs[8]  = '{MDU_MACL,   1'b1, 32'hFFFF8000, 32'h00000010, 32'hFFFFFFF0, 32'h10,       32'hFFFF8000, 32'h00000000, 6};
        vecs[9]  = '{MDU_MACW,   1'b1, 32'h00000055, 32'h7FFFFFF0, 32'h7FFF,     32'h7FFF,     32'h00000055, 32'h7FFFFFFF, 4};
        vecs[10] = '{MDU_MACW,   1'b0, 32'h0,        32'h80000000, 32'h7FFF,     32'h7FFF,     32'h00000000, 32'hBFFF0001, 4};
        vecs[11] = '{MDU_MACW,   1'b1, 32'h00000077, 32'h80000010, 32'h0000FFFF, 32'h100,      32'h00000077, 32'h80000000, 4};
        vecs[12] = '{MDU_MACW,   1'b0, 32'h0,        32'h0,        32'h0000FFFF, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFF, 4};
        vecs[13] = '{MDU_CLRMAC, 1'b0, 32'h1234,     32'h5678,     32'h0,        32'h0,        32'h0,        32'h0,        1};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = MDU_MULL; bus.in_s = 1'b0;
        bus.in_opl = 32'd0; bus.in_oph = 32'd0; bus.out_ready = 1'b1;
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_data = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mac", {bus.mach, bus.macl}, 64'd0);
        rst = 1'b0;

        lds(1'b1, 32'h00001234);
        check("lds_mach", 64'(bus.mach), 64'h00001234);

        for (int i = 0; i < 14; i++) begin
            lds(1'b1, vecs[i].mach0);
            lds(1'b0, vecs[i].macl0);
            run_op(vecs[i].op, vecs[i].s, vecs[i].opl, vecs[i].oph, lat);
            check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_mach", i), 64'(bus.mach), 64'(vecs[i].exp_mach));
            check($sformatf("v%0d_macl", i), 64'(bus.macl), 64'(vecs[i].exp_macl));
        end

        // Back-pressure on completion, plus an LDS attempt while busy.
        lds(1'b1, 32'h00001234);
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = MDU_MULSW; bus.in_s = 1'b0;
        bus.in_opl = 32'h2; bus.in_oph = 32'h3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.wr_en = 1'b1; bus.wr_sel = 1'b1; bus.wr_data = 32'hDEAD;
        @(negedge clk);
        bus.wr_en = 1'b0;
        wait_done(lat);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_out_valid", k), 64'(bus.out_valid), 64'd1);
            check($sformatf("stall%0d_in_ready", k), 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        check("stall_mach_kept", 64'(bus.mach), 64'h00001234);
        check("stall_macl", 64'(bus.macl), 64'h00000006);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        check("release_out_valid", 64'(bus.out_valid), 64'd0);

        // LDS and request in the same cycle: the op sees the written MACL.
        lds(1'b1, 32'h0);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_data = 32'h100;
        bus.in_valid = 1'b1; bus.in_op = MDU_MACW; bus.in_s = 1'b0;
        bus.in_opl = 32'h1; bus.in_oph = 32'h1;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.in_valid = 1'b0;
        wait_done(lat);
        check("wr_then_op_lat", 64'(lat), 64'd4);
        check("wr_then_op_mac", {bus.mach, bus.macl}, 64'h00000000_00000101);

        // Reset in the middle of DMULU.L.
        lds(1'b1, 32'hCAFE0000);
        lds(0, 32'h0000BEEF);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = MDU_DMULU; bus.in_opl = 32'hFFFFFFFF; bus.in_oph = 32'hFFFFFFFF;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_mac", {bus.mach, bus.macl}, 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_wb_valid", 64'(bus.out_valid), 64'd0);
        check("abort_no_wb_mac", {bus.mach, bus.macl}, 64'd0);
        run_op(MDU_CLRMAC, 1'b0, 32'h0, 32'h0, lat);
        check("clrmac_lat", 64'(lat), 64'd1);
        check("clrmac_mac", {bus.mach, bus.macl}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
